// File: rtl/fifo_pkg.sv
// Shared async-FIFO constants and Gray/binary pointer helpers.
// The helpers take zero-extended 32-bit operands, so one function pair serves every pointer width.
package fifo_pkg;

  localparam int unsigned ADDR_BITS_DEF = 4;
  localparam int unsigned PTR_BITS_DEF  = ADDR_BITS_DEF + 1;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = '0;
    for (int i = 0; i < 32; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter (XOR prefix from the MSB down).
module gray2bin_conv #(
  parameter int unsigned W = 5
) (
  input  logic [W-1:0] g,
  output logic [W-1:0] b
);

  always_comb begin
    b = '0;
    for (int i = 0; i < int'(W); i++) begin
      b[i] = ^(g >> i);
    end
  end

endmodule

// File: rtl/w_ptr_full_ctl.sv
// Write-domain pointer, full flag, fill level and sticky overflow for the async FIFO.
// Optional almost-full threshold compare is built when W_PTR_AFULL_EN is defined.
module w_ptr_full_ctl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_BITS = ADDR_BITS_DEF
) (
  input  logic                 w_clk,
  input  logic                 w_rst,
  input  logic                 w_inc,
  input  logic [ADDR_BITS:0]   ff2_r_ptr,
  input  logic                 w_ovf_clr,
`ifdef W_PTR_AFULL_EN
  input  logic [ADDR_BITS:0]   w_afull_thr,
  output logic                 w_afull,
`endif
  output logic [ADDR_BITS:0]   w_ptr,
  output logic [ADDR_BITS-1:0] w_addr,
  output logic                 w_full,
  output logic [ADDR_BITS:0]   w_level,
  output logic                 w_ovf
);

  localparam int unsigned PW = ADDR_BITS + 1;

  logic          wr_en;
  logic [PW-1:0] r_bin;
  logic [PW-1:0] r_ptr_full_cmp;

  logic [PW-1:0] w_bin_q,   w_bin_d;
  logic [PW-1:0] w_ptr_q,   w_ptr_d;
  logic          w_full_q,  w_full_d;
  logic [PW-1:0] w_level_q, w_level_d;
  logic          w_ovf_q,   w_ovf_d;
`ifdef W_PTR_AFULL_EN
  logic          w_afull_q, w_afull_d;
`endif

  gray2bin_conv #(.W(PW)) u_r_g2b (
    .g (ff2_r_ptr),
    .b (r_bin)
  );

  // Next-state pointers and flags; full/level look at the post-edge pointer so they never overshoot.
  always_comb begin
    wr_en          = w_inc & ~w_full_q;
    w_bin_d        = w_bin_q + PW'(wr_en);
    w_ptr_d        = PW'(bin2gray(32'(w_bin_d)));
    r_ptr_full_cmp = {~ff2_r_ptr[ADDR_BITS:ADDR_BITS-1], ff2_r_ptr[ADDR_BITS-2:0]};
    w_full_d       = (w_ptr_d == r_ptr_full_cmp);
    w_level_d      = w_bin_d - r_bin;
    w_ovf_d        = w_ovf_clr ? 1'b0 : w_ovf_q;
    if (w_inc && w_full_q) begin
      w_ovf_d = 1'b1;
    end
  end

`ifdef W_PTR_AFULL_EN
  always_comb begin
    w_afull_d = (w_level_d >= w_afull_thr);
  end
`endif

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      w_bin_q  <= '0;
      w_ptr_q  <= '0;
      w_full_q <= 1'b0;
    end else begin
      w_bin_q  <= w_bin_d;
      w_ptr_q  <= w_ptr_d;
      w_full_q <= w_full_d;
    end
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      w_level_q <= '0;
      w_ovf_q   <= 1'b0;
`ifdef W_PTR_AFULL_EN
      w_afull_q <= 1'b0;
`endif
    end else begin
      w_level_q <= w_level_d;
      w_ovf_q   <= w_ovf_d;
`ifdef W_PTR_AFULL_EN
      w_afull_q <= w_afull_d;
`endif
    end
  end

  assign w_ptr   = w_ptr_q;
  assign w_addr  = w_bin_q[ADDR_BITS-1:0];
  assign w_full  = w_full_q;
  assign w_level = w_level_q;
  assign w_ovf   = w_ovf_q;
`ifdef W_PTR_AFULL_EN
  assign w_afull = w_afull_q;
`endif

endmodule
